mem_arbiter: RTL and testbench

Memory-side responder for the cache miss protocol. It accepts line-fill petitions from the instruction cache, and fill or write-back petitions from the data cache. When both request at once it chooses one with round-robin arbitration. It runs one fixed-latency transaction against main memory and returns the line with a one-cycle service-ready pulse to the winning cache. It sits between both caches and the main memory model, one instance per core.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-side arbiter and the caches that talk to it.
// Line width and address width defaults must match both caches.
package mem_arbiter_pkg;

    localparam int CACHE_LINE_WIDTH = 256;
    localparam int ADDR_WIDTH       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } arbState_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between instruction and data caches.
// lastGrant starts at D so the instruction cache wins the first tie.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   reqI,
    input  logic   reqD,
    input  logic   update,
    output logic   grantValid,
    output owner_t grantOwner
);

    owner_t lastGrantReg;

    always_comb begin
        grantValid = reqI | reqD;
        grantOwner = OWNER_I;
        // D wins when alone, or on a tie when I had the previous grant.
        if (reqD && (!reqI || lastGrantReg == OWNER_I)) begin
            grantOwner = OWNER_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrantReg <= OWNER_D;
        end else if (update && grantValid) begin
            lastGrantReg <= grantOwner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side responder: arbitrates I/D cache misses and runs one fixed-latency
// memory transaction at a time, returning a one-cycle ready pulse to the owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int cache_line_width = CACHE_LINE_WIDTH,
    parameter int addr_width       = ADDR_WIDTH,
    parameter int mem_latency      = 5,
    parameter int line_offset_bits = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   iPetition,
    input  logic [addr_width-1:0]                  iAddr,
    output logic                                   iServiceReady,
    input  logic                                   dPetition,
    input  logic [addr_width-1:0]                  dAddr,
    input  logic                                   dIsWrite,
    input  logic [cache_line_width-1:0]            dDataToMem,
    output logic                                   dServiceReady,
    output logic [cache_line_width-1:0]            dataReadFromMem,
    output logic [addr_width-line_offset_bits-1:0] memAddr,
    output logic                                   memRead,
    output logic                                   memWrite,
    output logic [cache_line_width-1:0]            memDataToMem,
    input  logic [cache_line_width-1:0]            memDataFromMem
);

    arbState_t  stateReg, stateNext;
    owner_t     ownerReg;
    owner_t     grantOwner;
    logic       grantValid;
    logic       accept;
    logic       isWriteReg;
    logic [3:0] counterReg;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .reqI       (iPetition),
        .reqD       (dPetition),
        .update     (accept),
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    always_comb begin
        stateNext = stateReg;
        accept    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (grantValid) begin
                    accept    = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (counterReg == 4'd0) begin
                    stateNext = READY;
                end
            end
            READY:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg        <= IDLE;
            ownerReg        <= OWNER_I;
            isWriteReg      <= 1'b0;
            counterReg      <= 4'd0;
            memAddr         <= '0;
            memDataToMem    <= '0;
            dataReadFromMem <= '0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                ownerReg     <= grantOwner;
                memAddr      <= (grantOwner == OWNER_D) ? dAddr[addr_width-1:line_offset_bits]
                                                        : iAddr[addr_width-1:line_offset_bits];
                isWriteReg   <= (grantOwner == OWNER_D) && dIsWrite;
                memDataToMem <= dDataToMem;
                counterReg   <= 4'(mem_latency - 1);
            end else if (stateReg == BUSY) begin
                if (counterReg == 4'd0) begin
                    // Memory data is only valid on the final busy cycle of a read.
                    if (!isWriteReg) begin
                        dataReadFromMem <= memDataFromMem;
                    end
                end else begin
                    counterReg <= counterReg - 4'd1;
                end
            end
        end
    end

    assign iServiceReady = (stateReg == READY) && (ownerReg == OWNER_I);
    assign dServiceReady = (stateReg == READY) && (ownerReg == OWNER_D);
    assign memRead       = (stateReg == BUSY) && !isWriteReg;
    assign memWrite      = (stateReg == READY) && isWriteReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default latency instance plus a latency-2 build
// sharing the same stimulus.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 16;
    localparam int MW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          iPetition, dPetition, dIsWrite;
    logic [AW-1:0] iAddr, dAddr;
    logic [LW-1:0] dDataToMem, memDataFromMem;

    logic          iServiceReady, dServiceReady, memRead, memWrite;
    logic [LW-1:0] dataReadFromMem, memDataToMem;
    logic [MW-1:0] memAddr;

    logic          iServiceReady2, dServiceReady2, memRead2, memWrite2;
    logic [LW-1:0] dataReadFromMem2, memDataToMem2;
    logic [MW-1:0] memAddr2;

    logic [LW-1:0] patA, patB, patC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .iPetition(iPetition), .iAddr(iAddr), .iServiceReady(iServiceReady),
        .dPetition(dPetition), .dAddr(dAddr), .dIsWrite(dIsWrite), .dDataToMem(dDataToMem),
        .dServiceReady(dServiceReady), .dataReadFromMem(dataReadFromMem),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
        .memDataToMem(memDataToMem), .memDataFromMem(memDataFromMem)
    );

    mem_arbiter #(.mem_latency(2)) dut2 (
        .clk(clk), .reset(reset),
        .iPetition(iPetition), .iAddr(iAddr), .iServiceReady(iServiceReady2),
        .dPetition(dPetition), .dAddr(dAddr), .dIsWrite(dIsWrite), .dDataToMem(dDataToMem),
        .dServiceReady(dServiceReady2), .dataReadFromMem(dataReadFromMem2),
        .memAddr(memAddr2), .memRead(memRead2), .memWrite(memWrite2),
        .memDataToMem(memDataToMem2), .memDataFromMem(memDataFromMem)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({iServiceReady, dServiceReady, memRead, memWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 0000", {iServiceReady, dServiceReady, memRead, memWrite});
        end
        checks++;
        if (memAddr !== '0 || memDataToMem !== '0 || dataReadFromMem !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h nonzero data present expected all zero", memAddr);
        end
        reset = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_ifill();
        int lat = -1;
        int readCnt = 1;
        bit badD = 0;
        iAddr = 16'h1230;
        memDataFromMem = patA;
        iPetition = 1'b1;
        tick();
        checks++;
        if (memAddr !== 12'h123 || memRead !== 1'b1) begin
            errors++;
            $display("FAIL ifill_accept got addr=%h read=%b expected addr=123 read=1", memAddr, memRead);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dServiceReady) badD = 1;
            if (iServiceReady) begin lat = k; break; end
            if (memRead) readCnt++;
        end
        iPetition = 1'b0;
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL ifill_latency got %0d expected 5", lat); end
        checks++;
        if (readCnt !== 5 || memRead !== 1'b0) begin
            errors++;
            $display("FAIL ifill_memread got %0d cycles read_at_ready=%b expected 5 cycles read_at_ready=0", readCnt, memRead);
        end
        checks++;
        if (dataReadFromMem !== patA || badD || dServiceReady) begin
            errors++;
            $display("FAIL ifill_data got data_ok=%b dReady_seen=%b expected data_ok=1 dReady_seen=0", dataReadFromMem === patA, badD);
        end
        tick();
        checks++;
        if (iServiceReady !== 1'b0) begin errors++; $display("FAIL ifill_pulse_width got %b expected 0", iServiceReady); end
        $display("txn ifill addr=1230 latency=%0d", lat);
    endtask

    task automatic test_tie();
        int latI = -1;
        int latD = -1;
        int latI2 = -1;
        pulseReset();
        iAddr = 16'h0120;
        dAddr = 16'h0780;
        dIsWrite = 1'b0;
        memDataFromMem = patC;
        iPetition = 1'b1;
        dPetition = 1'b1;
        tick();
        checks++;
        if (memAddr !== 12'h012) begin errors++; $display("FAIL tie_first_owner got addr=%h expected 012", memAddr); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (iServiceReady) begin latI = k; break; end
        end
        checks++;
        if (latI !== 5 || dServiceReady !== 1'b0) begin
            errors++;
            $display("FAIL tie_i_ready got lat=%0d dReady=%b expected lat=5 dReady=0", latI, dServiceReady);
        end
        iPetition = 1'b0;
        tick();
        tick();
        checks++;
        if (memAddr !== 12'h078 || memRead !== 1'b1) begin
            errors++;
            $display("FAIL tie_d_accept got addr=%h read=%b expected addr=078 read=1", memAddr, memRead);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dServiceReady) begin latD = k; break; end
        end
        checks++;
        if (latD !== 5 || iServiceReady !== 1'b0 || dataReadFromMem !== patC) begin
            errors++;
            $display("FAIL tie_d_ready got lat=%0d iReady=%b data_ok=%b expected lat=5 iReady=0 data_ok=1",
                     latD, iServiceReady, dataReadFromMem === patC);
        end
        iAddr = 16'h0340;
        iPetition = 1'b1;
        tick();
        tick();
        iPetition = 1'b0;
        dPetition = 1'b0;
        checks++;
        if (memAddr !== 12'h034) begin errors++; $display("FAIL tie_second_owner got addr=%h expected 034", memAddr); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (iServiceReady) begin latI2 = k; break; end
        end
        checks++;
        if (latI2 !== 5) begin errors++; $display("FAIL tie_second_latency got %0d expected 5", latI2); end
        tick();
        $display("txn tie I=%0d D=%0d I2=%0d", latI, latD, latI2);
    endtask

    task automatic test_write();
        int lat = -1;
        bit badStrobe = 0;
        dAddr = 16'h0450;
        dDataToMem = patB;
        dIsWrite = 1'b1;
        memDataFromMem = patA;
        dPetition = 1'b1;
        tick();
        dPetition = 1'b0;
        checks++;
        if (memAddr !== 12'h045 || memDataToMem !== patB || memRead !== 1'b0 || memWrite !== 1'b0) begin
            errors++;
            $display("FAIL write_accept got addr=%h read=%b write=%b expected addr=045 read=0 write=0", memAddr, memRead, memWrite);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dServiceReady) begin lat = k; break; end
            if (memRead || memWrite) badStrobe = 1;
        end
        checks++;
        if (lat !== 5 || badStrobe) begin
            errors++;
            $display("FAIL write_latency got lat=%0d early_strobe=%b expected lat=5 early_strobe=0", lat, badStrobe);
        end
        checks++;
        if (memWrite !== 1'b1 || memRead !== 1'b0 || memAddr !== 12'h045 || memDataToMem !== patB || iServiceReady !== 1'b0) begin
            errors++;
            $display("FAIL write_ready got write=%b read=%b addr=%h iReady=%b expected write=1 read=0 addr=045 iReady=0",
                     memWrite, memRead, memAddr, iServiceReady);
        end
        checks++;
        if (dataReadFromMem !== patC) begin errors++; $display("FAIL write_keeps_fill_data got changed expected unchanged"); end
        tick();
        checks++;
        if (memWrite !== 1'b0) begin errors++; $display("FAIL write_pulse_width got %b expected 0", memWrite); end
        dIsWrite = 1'b0;
        $display("txn write addr=0450 latency=%0d", lat);
    endtask

    task automatic test_withdraw();
        int lat = -1;
        int latD = -1;
        iAddr = 16'h2220;
        iPetition = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) iPetition = 1'b0;
            if (iServiceReady) begin lat = k; break; end
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL withdraw_latency got %0d expected 5", lat); end
        tick();
        dAddr = 16'h0990;
        dIsWrite = 1'b0;
        dPetition = 1'b1;
        tick();
        dPetition = 1'b0;
        checks++;
        if (memAddr !== 12'h099 || memRead !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_next_accept got addr=%h read=%b expected addr=099 read=1", memAddr, memRead);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dServiceReady) begin latD = k; break; end
        end
        checks++;
        if (latD !== 5) begin errors++; $display("FAIL withdraw_next_latency got %0d expected 5", latD); end
        tick();
        $display("txn withdraw latency=%0d next=%0d", lat, latD);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        dAddr = 16'h0560;
        dDataToMem = patB;
        dIsWrite = 1'b1;
        dPetition = 1'b1;
        tick();
        dPetition = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({memRead, memWrite, iServiceReady, dServiceReady} !== 4'b0000 ||
            memAddr !== '0 || memDataToMem !== '0 || dataReadFromMem !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got strobes=%b addr=%h expected strobes=0000 addr=000 data zero",
                     {memRead, memWrite, iServiceReady, dServiceReady}, memAddr);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (memWrite || iServiceReady || dServiceReady) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_no_pulse got pulse expected none"); end
        dIsWrite = 1'b0;
        $display("txn reset_mid pulse_seen=%b", seen);
    endtask

    task automatic test_lat2();
        int lat1 = -1;
        int gap = -1;
        int lat2 = -1;
        pulseReset();
        iAddr = 16'h0AB0;
        memDataFromMem = patA;
        iPetition = 1'b1;
        tick();
        checks++;
        if (memAddr2 !== 12'h0AB || memRead2 !== 1'b1) begin
            errors++;
            $display("FAIL lat2_accept got addr=%h read=%b expected addr=0ab read=1", memAddr2, memRead2);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (iServiceReady2) begin lat1 = k; break; end
        end
        checks++;
        if (lat1 !== 2 || dataReadFromMem2 !== patA) begin
            errors++;
            $display("FAIL lat2_fill got lat=%0d data_ok=%b expected lat=2 data_ok=1", lat1, dataReadFromMem2 === patA);
        end
        // Petition held high: the next acceptance follows one idle cycle after READY.
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (memRead2) begin gap = k; break; end
        end
        checks++;
        if (gap !== 2) begin errors++; $display("FAIL lat2_reaccept got %0d edges after ready expected 2", gap); end
        iPetition = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (iServiceReady2) begin lat2 = k; break; end
        end
        checks++;
        if (lat2 !== 2) begin errors++; $display("FAIL lat2_second_latency got %0d expected 2", lat2); end
        tick();
        $display("txn lat2 first=%0d reaccept=%0d second=%0d", lat1, gap, lat2);
    endtask

    initial begin
        patA = {8{32'hDEADBEEF}};
        patB = {8{32'h0BADF00D}};
        patC = {8{32'h12345678}};
        reset = 1'b0;
        iPetition = 1'b0;
        dPetition = 1'b0;
        dIsWrite = 1'b0;
        iAddr = '0;
        dAddr = '0;
        dDataToMem = '0;
        memDataFromMem = '0;
        test_reset();
        test_ifill();
        test_tie();
        test_write();
        test_withdraw();
        test_reset_mid();
        test_lat2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
